// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, write-back
// encodings, FSM states and instruction field helpers.
package cpu_pkg;

    localparam int INSTR_W = 9;
    localparam int CNT_W   = 16;

    localparam int OPC_HI = 8;
    localparam int OPC_LO = 6;
    localparam int RX_HI  = 5;
    localparam int RX_LO  = 3;
    localparam int RY_HI  = 2;
    localparam int RY_LO  = 0;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOVE = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_TERM = 3'b100;

    localparam logic [1:0] WB_IMM  = 2'b00;
    localparam logic [1:0] WB_REGB = 2'b01;
    localparam logic [1:0] WB_ALU  = 2'b10;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_XOR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_STEP   = 3'd4,
        S_SETTLE = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    function automatic logic [2:0] ir_opcode(input logic [INSTR_W-1:0] ir);
        return ir[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [2:0] ir_rx(input logic [INSTR_W-1:0] ir);
        return ir[RX_HI:RX_LO];
    endfunction

    function automatic logic [2:0] ir_ry(input logic [INSTR_W-1:0] ir);
        return ir[RY_HI:RY_LO];
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// ROM and register-file bus between the sequencer (master) and the datapath (slave).
interface cpu_seq_ctrl_if #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
);
    import cpu_pkg::*;

    logic [INSTR_W-1:0] instruction;
    logic [DATA_W-1:0]  data_var;
    logic               step;
    logic [RADDR_W-1:0] rd_addr_a;
    logic [RADDR_W-1:0] rd_addr_b;
    logic               alu_op;
    logic [1:0]         wr_sel;
    logic [RADDR_W-1:0] wr_addr;
    logic               wr_en;
    logic [DATA_W-1:0]  imm;

    modport master (
        input  instruction, data_var,
        output step, rd_addr_a, rd_addr_b, alu_op, wr_sel, wr_addr, wr_en, imm
    );

    modport slave (
        output instruction, data_var,
        input  step, rd_addr_a, rd_addr_b, alu_op, wr_sel, wr_addr, wr_en, imm
    );

endinterface

// File: rtl/cpu_decode.sv
// Combinational instruction classifier: splits the latched ROM word into
// class flags, ALU operation and register fields.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] i_ir,
    output logic               o_is_load,
    output logic               o_is_move,
    output logic               o_is_alu,
    output logic               o_is_term,
    output logic               o_illegal,
    output logic               o_alu_op,
    output logic [2:0]         o_rx,
    output logic [2:0]         o_ry
);

    logic [2:0] w_op;

    assign w_op = ir_opcode(i_ir);
    assign o_rx = ir_rx(i_ir);
    assign o_ry = ir_ry(i_ir);

    // Opcode classification; any unlisted opcode is illegal
    always_comb begin
        o_is_load = 1'b0;
        o_is_move = 1'b0;
        o_is_alu  = 1'b0;
        o_is_term = 1'b0;
        o_illegal = 1'b0;
        o_alu_op  = ALU_ADD;
        case (w_op)
            OP_LOAD: o_is_load = 1'b1;
            OP_MOVE: o_is_move = 1'b1;
            OP_ADD: begin
                o_is_alu = 1'b1;
                o_alu_op = ALU_ADD;
            end
            OP_XOR: begin
                o_is_alu = 1'b1;
                o_alu_op = ALU_XOR;
            end
            OP_TERM: o_is_term = 1'b1;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer for the 16-bit register/ALU datapath: fetches a ROM
// word, strobes one register write, pulses step, and halts on TERM/illegal/watchdog.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int RADDR_W   = 3,
    parameter int MAX_INSTR = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    cpu_seq_ctrl_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INSTR);

    state_e             r_state;
    logic [INSTR_W-1:0] r_ir;
    logic [DATA_W-1:0]  r_imm;
    logic               r_step;
    logic               r_wr_en;
    logic [RADDR_W-1:0] r_rd_a;
    logic [RADDR_W-1:0] r_rd_b;
    logic [RADDR_W-1:0] r_wr_addr;
    logic               r_alu_op;
    logic [1:0]         r_wr_sel;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_is_load;
    logic               w_is_move;
    logic               w_is_alu;
    logic               w_is_term;
    logic               w_illegal;
    logic               w_alu_op;
    logic [2:0]         w_rx;
    logic [2:0]         w_ry;
    logic [CNT_W-1:0]   w_cnt_next;

    cpu_decode u_decode (
        .i_ir      (r_ir),
        .o_is_load (w_is_load),
        .o_is_move (w_is_move),
        .o_is_alu  (w_is_alu),
        .o_is_term (w_is_term),
        .o_illegal (w_illegal),
        .o_alu_op  (w_alu_op),
        .o_rx      (w_rx),
        .o_ry      (w_ry)
    );

    // Retired-instruction count, saturating at the counter's full scale
    always_comb begin
        if (r_cnt == {CNT_W{1'b1}}) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Sequencer: state and every output register; step/wr_en are single-cycle strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_imm     <= '0;
            r_step    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_a    <= '0;
            r_rd_b    <= '0;
            r_wr_addr <= '0;
            r_alu_op  <= ALU_ADD;
            r_wr_sel  <= WB_IMM;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_step  <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_ir    <= bus.instruction;
                    r_imm   <= bus.data_var;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_rd_a    <= RADDR_W'(w_rx);
                    r_rd_b    <= RADDR_W'(w_ry);
                    r_wr_addr <= RADDR_W'(w_rx);
                    r_alu_op  <= w_alu_op;
                    if (w_is_load) begin
                        r_wr_sel <= WB_IMM;
                        r_wr_en  <= 1'b1;
                        r_state  <= S_STEP;
                    end else if (w_is_move) begin
                        r_wr_sel <= WB_REGB;
                        r_wr_en  <= 1'b1;
                        r_state  <= S_STEP;
                    end else if (w_is_alu) begin
                        r_state <= S_WB;
                    end else if (w_is_term) begin
                        r_state <= S_HALT;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_HALT;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                S_WB: begin
                    r_wr_sel <= WB_ALU;
                    r_wr_en  <= 1'b1;
                    r_state  <= S_STEP;
                end
                S_STEP: begin
                    r_step <= 1'b1;
                    r_cnt  <= w_cnt_next;
                    if (w_cnt_next == MAX_CNT) begin
                        r_state <= S_HALT;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (!pause) begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.step      = r_step;
    assign bus.rd_addr_a = r_rd_a;
    assign bus.rd_addr_b = r_rd_b;
    assign bus.alu_op    = r_alu_op;
    assign bus.wr_sel    = r_wr_sel;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_en     = r_wr_en;
    assign bus.imm       = r_imm;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign instr_count   = r_cnt;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench: behavioural ROM + register file around the sequencer, a
// table of single-instruction programs, and hand sequences for timing corners.
module tb_cpu_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, pause, start_wd, mdl_clr;
    logic        busy, done, err;
    logic [15:0] instr_count;
    logic        wd_busy, wd_done, wd_err;
    logic [15:0] wd_count;

    cpu_seq_ctrl_if #(.DATA_W(16), .RADDR_W(3)) bus ();
    cpu_seq_ctrl_if #(.DATA_W(16), .RADDR_W(3)) wbus ();

    cpu_seq_ctrl #(.DATA_W(16), .RADDR_W(3), .MAX_INSTR(256)) u_dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .bus(bus),
        .busy(busy), .done(done), .err(err), .instr_count(instr_count)
    );

    cpu_seq_ctrl #(.DATA_W(16), .RADDR_W(3), .MAX_INSTR(3)) u_wd (
        .clk(clk), .reset(reset), .start(start_wd), .pause(1'b0), .bus(wbus),
        .busy(wd_busy), .done(wd_done), .err(wd_err), .instr_count(wd_count)
    );

    // Behavioural ROM, register file and pulse monitors
    logic [8:0]  rom_i [16];
    logic [15:0] rom_d [16];
    logic [3:0]  rom_addr;
    logic [15:0] rf [8];
    logic [15:0] wdata;
    logic [5:0]  m_cyc;
    logic [63:0] wr_mask, step_mask;
    int          wr_cnt, step_cnt, wd_step_cnt;

    assign bus.instruction  = rom_i[rom_addr];
    assign bus.data_var     = rom_d[rom_addr];
    assign wbus.instruction = 9'b000_000_000;
    assign wbus.data_var    = 16'h1234;

    always_comb begin
        case (bus.wr_sel)
            2'b00:   wdata = bus.imm;
            2'b01:   wdata = rf[bus.rd_addr_b];
            2'b10:   wdata = bus.alu_op ? (rf[bus.rd_addr_a] ^ rf[bus.rd_addr_b])
                                        : (rf[bus.rd_addr_a] + rf[bus.rd_addr_b]);
            default: wdata = 16'hxxxx;
        endcase
    end

    always @(posedge clk) begin
        if (mdl_clr) rom_addr <= 4'd0;
        else if (bus.step) rom_addr <= rom_addr + 4'd1;
        if (bus.wr_en) rf[bus.wr_addr] <= wdata;
        if (start) m_cyc <= 6'd1;
        else if (m_cyc != 6'd63) m_cyc <= m_cyc + 6'd1;
    end

    always @(negedge clk) begin
        if (mdl_clr) begin
            wr_mask <= 64'd0; step_mask <= 64'd0;
            wr_cnt <= 0; step_cnt <= 0; wd_step_cnt <= 0;
        end else begin
            if (bus.wr_en) begin wr_cnt <= wr_cnt + 1; wr_mask <= wr_mask | (64'd1 << m_cyc); end
            if (bus.step) begin step_cnt <= step_cnt + 1; step_mask <= step_mask | (64'd1 << m_cyc); end
            if (wbus.step) wd_step_cnt <= wd_step_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_step"},  64'(bus.step), 64'd0);
        check({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_err"},   64'(err), 64'd0);
        check({tag, "_addrs"}, 64'({bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr}), 64'd0);
        check({tag, "_alu_sel"}, 64'({bus.alu_op, bus.wr_sel}), 64'd0);
        check({tag, "_imm"},   64'(bus.imm), 64'd0);
        check({tag, "_count"}, 64'(instr_count), 64'd0);
    endtask

    task automatic clear_model();
        mdl_clr = 1'b1;
        repeat (2) @(negedge clk);
        mdl_clr = 1'b0;
    endtask

    // Leaves the caller at the falling edge of cycle 1 (the FETCH cycle)
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [8:0]  word;
        logic [15:0] data;
        int          chk_reg;
        logic [15:0] exp_val;
        int          exp_cyc;
        int          exp_steps;
        int          exp_wr;
        logic        exp_err;
        int          exp_cnt;
    } vec_t;

    localparam int NV = 10;
    localparam logic [8:0] TERM = 9'b100_000_000;

    initial begin
        vec_t vecs [NV];
        int cyc;

        vecs[0] = '{9'b000_011_000, 16'hFFFF, 3, 16'hFFFF, 7, 1, 1, 1'b0, 1}; // load r3
        vecs[1] = '{9'b000_010_000, 16'h0002, 2, 16'h0002, 7, 1, 1, 1'b0, 1}; // load r2
        vecs[2] = '{9'b010_011_010, 16'h0000, 3, 16'h0001, 8, 1, 1, 1'b0, 1}; // add r3,r2 wraps
        vecs[3] = '{9'b011_010_011, 16'h0000, 2, 16'h0003, 8, 1, 1, 1'b0, 1}; // xor r2,r3
        vecs[4] = '{9'b001_111_010, 16'h0000, 7, 16'h0003, 7, 1, 1, 1'b0, 1}; // move r7,r2
        vecs[5] = '{TERM,           16'h0000, 7, 16'h0003, 3, 0, 0, 1'b0, 0}; // term only
        vecs[6] = '{9'b101_111_111, 16'hDEAD, 7, 16'h0003, 3, 0, 0, 1'b1, 0}; // illegal 101
        vecs[7] = '{9'b110_011_000, 16'h5555, 3, 16'h0001, 3, 0, 0, 1'b1, 0}; // illegal 110
        vecs[8] = '{9'b111_010_001, 16'h0000, 2, 16'h0003, 3, 0, 0, 1'b1, 0}; // illegal 111
        vecs[9] = '{9'b011_011_011, 16'h0000, 3, 16'h0000, 8, 1, 1, 1'b0, 1}; // xor r3,r3; err cleared

        reset = 1'b1; start = 1'b0; start_wd = 1'b0; pause = 1'b0; mdl_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        check("rst_wd_done", 64'(wd_done), 64'd0);
        reset = 1'b0;
        mdl_clr = 1'b0;

        for (int i = 0; i < NV; i++) begin
            clear_model();
            rom_i[0] = vecs[i].word; rom_d[0] = vecs[i].data;
            rom_i[1] = TERM;         rom_d[1] = 16'h0000;
            pulse_start();
            wait_done(1, cyc);
            check($sformatf("v%0d_done_cycle", i), 64'(cyc), 64'(vecs[i].exp_cyc));
            check($sformatf("v%0d_steps", i), 64'(step_cnt), 64'(vecs[i].exp_steps));
            check($sformatf("v%0d_wr_en", i), 64'(wr_cnt), 64'(vecs[i].exp_wr));
            check($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_count", i), 64'(instr_count), 64'(vecs[i].exp_cnt));
            check($sformatf("v%0d_reg", i), 64'(rf[vecs[i].chk_reg]), 64'(vecs[i].exp_val));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
        end

        // Full program
        clear_model();
        rom_i[0] = 9'b000_000_000; rom_d[0] = 16'd5;
        rom_i[1] = 9'b000_001_000; rom_d[1] = 16'd4;
        rom_i[2] = 9'b010_001_000; rom_d[2] = 16'd0;
        rom_i[3] = 9'b001_110_000; rom_d[3] = 16'd0;
        rom_i[4] = 9'b011_110_001; rom_d[4] = 16'd0;
        rom_i[5] = TERM;           rom_d[5] = 16'd0;
        pulse_start();
        wait_done(1, cyc);
        check("prog_done_cycle", 64'(cyc), 64'd25);
        check("prog_r0", 64'(rf[0]), 64'd5);
        check("prog_r1", 64'(rf[1]), 64'd9);
        check("prog_r6", 64'(rf[6]), 64'd12);
        check("prog_steps", 64'(step_cnt), 64'd5);
        check("prog_wr_en", 64'(wr_cnt), 64'd5);
        check("prog_count", 64'(instr_count), 64'd5);
        check("prog_err", 64'(err), 64'd0);

        // Per-cycle LOAD timing
        clear_model();
        rom_i[0] = 9'b000_011_000; rom_d[0] = 16'hFFFF;
        rom_i[1] = TERM;           rom_d[1] = 16'h0000;
        pulse_start();
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("ld_c%0d_wr_en", c), 64'(bus.wr_en), 64'(c == 3));
            check($sformatf("ld_c%0d_step", c), 64'(bus.step), 64'(c == 4));
            if (c == 3) begin
                check("ld_wr_sel", 64'(bus.wr_sel), 64'd0);
                check("ld_imm", 64'(bus.imm), 64'hFFFF);
                check("ld_wr_addr", 64'(bus.wr_addr), 64'd3);
            end
            @(negedge clk);
        end
        wait_done(6, cyc);
        check("ld_done_cycle", 64'(cyc), 64'd7);

        // ADD overflow: write strobes only for the loads and the ADD write-back
        clear_model();
        rom_i[0] = 9'b000_010_000; rom_d[0] = 16'hFFFF;
        rom_i[1] = 9'b000_011_000; rom_d[1] = 16'h0002;
        rom_i[2] = 9'b010_010_011; rom_d[2] = 16'h0000;
        rom_i[3] = TERM;           rom_d[3] = 16'h0000;
        pulse_start();
        wait_done(1, cyc);
        check("ovf_done_cycle", 64'(cyc), 64'd16);
        check("ovf_r2", 64'(rf[2]), 64'h0001);
        check("ovf_wr_cycles", wr_mask, 64'h1088);
        check("ovf_step_cycles", step_mask, 64'h2110);

        // Watchdog with MAX_INSTR=3 on an endless stream of loads
        clear_model();
        @(negedge clk);
        start_wd = 1'b1;
        @(posedge clk);
        #1 start_wd = 1'b0;
        @(negedge clk);
        cyc = 1;
        while (wd_done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("wd_done_cycle", 64'(cyc), 64'd12);
        check("wd_err", 64'(wd_err), 64'd1);
        check("wd_count", 64'(wd_count), 64'd3);
        repeat (6) @(negedge clk);
        check("wd_steps", 64'(wd_step_cnt), 64'd3);
        check("wd_busy", 64'(wd_busy), 64'd0);

        // Pause held in SETTLE
        clear_model();
        rom_i[0] = 9'b000_100_000; rom_d[0] = 16'd7;
        rom_i[1] = 9'b000_101_000; rom_d[1] = 16'd8;
        rom_i[2] = TERM;           rom_d[2] = 16'd0;
        pause = 1'b1;
        pulse_start();
        repeat (13) @(negedge clk);
        check("pause_steps", 64'(step_cnt), 64'd1);
        check("pause_wr_en", 64'(wr_cnt), 64'd1);
        check("pause_busy", 64'(busy), 64'd1);
        check("pause_imm", 64'(bus.imm), 64'd7);
        pause = 1'b0;
        wait_done(14, cyc);
        check("pause_done_cycle", 64'(cyc), 64'd21);
        check("pause_steps_end", 64'(step_cnt), 64'd2);
        check("pause_r5", 64'(rf[5]), 64'd8);

        // Reset during the ADD write-back cycle abandons the write
        clear_model();
        rom_i[0] = 9'b000_010_000; rom_d[0] = 16'd1;
        rom_i[1] = 9'b010_010_010; rom_d[1] = 16'd0;
        rom_i[2] = TERM;           rom_d[2] = 16'd0;
        pulse_start();
        repeat (6) @(negedge clk);
        check("wbrst_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("wbrst");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("wbrst_wr_en", 64'(wr_cnt), 64'd1);
        check("wbrst_steps", 64'(step_cnt), 64'd1);
        check("wbrst_r2", 64'(rf[2]), 64'd1);
        check("wbrst_idle", 64'({busy, done}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
